// File: rtl/armstrong_pkg.sv
// Shared types, register map and width helpers for the
// narcissistic-number checker peripheral.
package armstrong_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SPLIT,
    S_POWER,
    S_COMPARE
  } state_e;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_NUMBER = 2'd1;
  localparam logic [1:0] A_STATUS = 2'd2;
  localparam logic [1:0] A_SUM    = 2'd3;

  localparam int C_START = 0;
  localparam int C_MODE  = 1;
  localparam int C_IRQEN = 2;

  localparam int ST_BUSY   = 0;
  localparam int ST_DONE   = 1;
  localparam int ST_RESULT = 2;
  localparam int ST_ERR    = 3;

  function automatic int calc_max_digits(input int num_w);
    longint v;
    int d;
    v = (longint'(1) << num_w) - 1;
    d = 1;
    while (v >= 10) begin
      v = v / 10;
      d = d + 1;
    end
    return d;
  endfunction

  function automatic int calc_sum_w(input int num_w);
    return num_w + 4;
  endfunction

endpackage

// File: rtl/armstrong_engine_digit_step.sv
// One decimal digit peel: n -> {n/10, n%10}.
// Purely combinational, used once per SPLIT cycle.
module armstrong_digit_step #(
  parameter int NUM_W = 16
) (
  input  logic [NUM_W-1:0] n_i,
  output logic [NUM_W-1:0] quot_o,
  output logic [3:0]       rem_o
);

  localparam logic [NUM_W-1:0] TEN = NUM_W'(10);

  assign quot_o = n_i / TEN;
  assign rem_o  = 4'(n_i % TEN);

endmodule

// File: rtl/armstrong_engine.sv
// Bus-mapped Armstrong number checker: register decode,
// sequential split/power/compare FSM and result registers.
module armstrong_engine
  import armstrong_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NUM_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              iChip_select_n,
  input  logic              iWrite_n,
  input  logic              iRead_n,
  input  logic [1:0]        iAddr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              oIrq
);

  localparam int MAX_DIGITS = calc_max_digits(NUM_W);
  localparam int SUM_W      = calc_sum_w(NUM_W);

  state_e state_q, state_d;

  logic mode_q, mode_d;
  logic irq_en_q, irq_en_d;
  logic mode_run_q, mode_run_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic result_q, result_d;
  logic err_q, err_d;
  logic irq_q, irq_d;

  logic [NUM_W-1:0] number_q, number_d;
  logic [NUM_W-1:0] opnd_q, opnd_d;
  logic [NUM_W-1:0] n_q, n_d;

  logic [3:0] dcnt_q, dcnt_d;
  logic [3:0] e_q, e_d;
  logic [3:0] ecnt_q, ecnt_d;
  logic [3:0] didx_q, didx_d;

  logic [SUM_W-1:0] sum_q, sum_d;
  logic [SUM_W-1:0] p_q, p_d;

  logic [4*MAX_DIGITS-1:0] dbuf_q, dbuf_d;
  logic [DATA_W-1:0]       dout_q, dout_d;

  logic              wr_en, rd_en;
  logic              wr_ctrl, wr_num, wr_stat;
  logic              start_req;
  logic [NUM_W-1:0]  quot;
  logic [3:0]        rem;
  logic [3:0]        dig_cur;
  logic [SUM_W-1:0]  p_mul;
  logic [DATA_W-1:0] rd_data;
  logic              unused_in;

  assign unused_in = ^data_in;

  assign wr_en     = !iChip_select_n && !iWrite_n;
  assign rd_en     = !iChip_select_n && !iRead_n;
  assign wr_ctrl   = wr_en && (iAddr == A_CTRL);
  assign wr_num    = wr_en && (iAddr == A_NUMBER);
  assign wr_stat   = wr_en && (iAddr == A_STATUS);
  assign start_req = wr_ctrl && data_in[C_START];

  armstrong_digit_step #(
    .NUM_W (NUM_W)
  ) u_step (
    .n_i    (n_q),
    .quot_o (quot),
    .rem_o  (rem)
  );

  assign dig_cur = dbuf_q[4*int'(didx_q) +: 4];
  assign p_mul   = p_q * SUM_W'(dig_cur);

  always_comb begin
    rd_data = '0;
    unique case (iAddr)
      A_CTRL: begin
        rd_data[C_MODE]  = mode_q;
        rd_data[C_IRQEN] = irq_en_q;
      end
      A_NUMBER: rd_data = DATA_W'(number_q);
      A_STATUS: begin
        rd_data[ST_BUSY]   = busy_q;
        rd_data[ST_DONE]   = done_q;
        rd_data[ST_RESULT] = result_q;
        rd_data[ST_ERR]    = err_q;
        rd_data[7:4]       = dcnt_q;
      end
      A_SUM:    rd_data = DATA_W'(sum_q);
      default:  rd_data = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    irq_en_d   = irq_en_q;
    mode_run_d = mode_run_q;
    busy_d     = busy_q;
    done_d     = done_q;
    result_d   = result_q;
    err_d      = err_q;
    number_d   = number_q;
    opnd_d     = opnd_q;
    n_d        = n_q;
    dcnt_d     = dcnt_q;
    e_d        = e_q;
    ecnt_d     = ecnt_q;
    didx_d     = didx_q;
    sum_d      = sum_q;
    p_d        = p_q;
    dbuf_d     = dbuf_q;
    dout_d     = rd_en ? rd_data : dout_q;
    irq_d      = done_q & irq_en_q;

    if (wr_ctrl) begin
      mode_d   = data_in[C_MODE];
      irq_en_d = data_in[C_IRQEN];
    end
    if (wr_num) begin
      if (busy_q) err_d = 1'b1;
      else        number_d = data_in[NUM_W-1:0];
    end
    if (start_req && busy_q) err_d = 1'b1;
    if (wr_stat) begin
      if (data_in[ST_DONE]) done_d = 1'b0;
      if (data_in[ST_ERR])  err_d  = 1'b0;
    end

    // Completion below overrides a same-cycle done-clear.
    unique case (state_q)
      S_IDLE: begin
        if (start_req) begin
          opnd_d     = number_q;
          n_d        = number_q;
          mode_run_d = data_in[C_MODE];
          done_d     = 1'b0;
          result_d   = 1'b0;
          sum_d      = '0;
          busy_d     = 1'b1;
          dcnt_d     = '0;
          dbuf_d     = '0;
          state_d    = S_SPLIT;
        end
      end
      S_SPLIT: begin
        dbuf_d[4*int'(dcnt_q) +: 4] = rem;
        n_d    = quot;
        dcnt_d = dcnt_q + 4'd1;
        if (quot == '0) begin
          e_d     = mode_run_q ? 4'd3 : dcnt_q + 4'd1;
          ecnt_d  = '0;
          didx_d  = '0;
          p_d     = SUM_W'(1);
          state_d = S_POWER;
        end
      end
      S_POWER: begin
        if (ecnt_q == e_q - 4'd1) begin
          sum_d  = sum_q + p_mul;
          p_d    = SUM_W'(1);
          ecnt_d = '0;
          didx_d = didx_q + 4'd1;
          if (didx_q == dcnt_q - 4'd1) state_d = S_COMPARE;
        end else begin
          p_d    = p_mul;
          ecnt_d = ecnt_q + 4'd1;
        end
      end
      S_COMPARE: begin
        result_d = (sum_q == SUM_W'(opnd_q));
        busy_d   = 1'b0;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      mode_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      mode_run_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= 1'b0;
      err_q      <= 1'b0;
      irq_q      <= 1'b0;
      number_q   <= '0;
      opnd_q     <= '0;
      n_q        <= '0;
      dcnt_q     <= '0;
      e_q        <= '0;
      ecnt_q     <= '0;
      didx_q     <= '0;
      sum_q      <= '0;
      p_q        <= '0;
      dbuf_q     <= '0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      irq_en_q   <= irq_en_d;
      mode_run_q <= mode_run_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      err_q      <= err_d;
      irq_q      <= irq_d;
      number_q   <= number_d;
      opnd_q     <= opnd_d;
      n_q        <= n_d;
      dcnt_q     <= dcnt_d;
      e_q        <= e_d;
      ecnt_q     <= ecnt_d;
      didx_q     <= didx_d;
      sum_q      <= sum_d;
      p_q        <= p_d;
      dbuf_q     <= dbuf_d;
      dout_q     <= dout_d;
    end
  end

  assign data_out = dout_q;
  assign oIrq     = irq_q;

endmodule

// File: tb/tb_armstrong_engine.sv
// Directed bench for armstrong_engine: vector table
// plus hand-written handshake and reset sequences.
module tb_armstrong_engine;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_NUMBER = 2'd1;
  localparam logic [1:0] A_STATUS = 2'd2;
  localparam logic [1:0] A_SUM    = 2'd3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cs_n, wr_n, rd_n;
  logic [1:0]  addr;
  logic [15:0] din;
  logic [15:0] dout;
  logic        irq;

  int n_vec = 0;
  int n_bad = 0;

  armstrong_engine #(
    .DATA_W (16),
    .NUM_W  (16)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .iChip_select_n (cs_n),
    .iWrite_n       (wr_n),
    .iRead_n        (rd_n),
    .iAddr          (addr),
    .data_in        (din),
    .data_out       (dout),
    .oIrq           (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] num;
    logic        mode;
    int          d;
    logic        res;
    logic [15:0] sum;
    int          edge_n;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    cs_n = 1'b0; wr_n = 1'b0; addr = a; din = d;
    @(posedge clk);
    #1;
    cs_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [15:0] d);
    @(negedge clk);
    cs_n = 1'b0; rd_n = 1'b0; addr = a;
    @(posedge clk);
    #1;
    d = dout;
    cs_n = 1'b1; rd_n = 1'b1;
  endtask

  task automatic start(input logic [15:0] num, input logic [15:0] ctrl);
    wr(A_NUMBER, num);
    wr(A_CTRL, ctrl);
  endtask

  // Polls STATUS each cycle; data_out after edge k shows state after k-1.
  task automatic wait_done(output int edge_n, output logic first_busy,
                           output logic irq_prev, output logic irq_at);
    edge_n = -1; first_busy = 1'b0; irq_prev = 1'b0; irq_at = 1'b0;
    cs_n = 1'b0; rd_n = 1'b0; addr = A_STATUS;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) first_busy = dout[0];
      if (dout[1]) begin
        edge_n = k - 1;
        irq_at = irq;
        break;
      end
      irq_prev = irq;
    end
    cs_n = 1'b1; rd_n = 1'b1;
  endtask

  initial begin
    logic [15:0] v;
    int          e;
    logic        fb, ip, ia;

    tbl[0] = '{16'd153,   1'b0, 3, 1'b1, 16'd153,   13};
    tbl[1] = '{16'd9474,  1'b0, 4, 1'b1, 16'd9474,  21};
    tbl[2] = '{16'd154,   1'b0, 3, 1'b0, 16'd190,   13};
    tbl[3] = '{16'd0,     1'b0, 1, 1'b1, 16'd0,     3};
    tbl[4] = '{16'd1634,  1'b1, 4, 1'b0, 16'd308,   17};
    tbl[5] = '{16'd1634,  1'b0, 4, 1'b1, 16'd1634,  21};
    tbl[6] = '{16'd370,   1'b1, 3, 1'b1, 16'd370,   13};
    tbl[7] = '{16'd65535, 1'b0, 5, 1'b0, 16'd17394, 31};
    tbl[8] = '{16'd9,     1'b0, 1, 1'b1, 16'd9,     3};
    tbl[9] = '{16'd10,    1'b1, 2, 1'b0, 16'd1,     9};

    reset_n = 1'b0;
    cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
    addr = 2'd0; din = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    rd(A_CTRL, v);   chk("rst_ctrl", 32'(v), 32'h0);
    rd(A_NUMBER, v); chk("rst_number", 32'(v), 32'h0);
    rd(A_STATUS, v); chk("rst_status", 32'(v), 32'h0);
    rd(A_SUM, v);    chk("rst_sum", 32'(v), 32'h0);

    wr(A_CTRL, 16'h0006);
    rd(A_CTRL, v); chk("ctrl_rw", 32'(v), 32'h6);
    wr(A_CTRL, 16'h0000);

    // Read and write NUMBER in the same cycle
    wr(A_NUMBER, 16'd42);
    @(negedge clk);
    cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0; addr = A_NUMBER; din = 16'd777;
    @(posedge clk);
    #1;
    chk("rw_same_pre", 32'(dout), 32'd42);
    cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    rd(A_NUMBER, v); chk("rw_same_post", 32'(v), 32'd777);

    for (int i = 0; i < 10; i++) begin
      start(tbl[i].num, {14'd0, tbl[i].mode, 1'b1});
      wait_done(e, fb, ip, ia);
      chk($sformatf("v%0d_done_edge", i), 32'(e), 32'(tbl[i].edge_n));
      chk($sformatf("v%0d_busy", i), 32'(fb), 32'h1);
      rd(A_STATUS, v);
      chk($sformatf("v%0d_status", i), 32'(v),
          32'((tbl[i].d << 4) | 2 | (int'(tbl[i].res) << 2)));
      rd(A_SUM, v);
      chk($sformatf("v%0d_sum", i), 32'(v), 32'(tbl[i].sum));
    end

    // Writes while busy are dropped and flag err
    start(16'd153, 16'h0001);
    wr(A_NUMBER, 16'd5);
    wr(A_CTRL, 16'h0001);
    wait_done(e, fb, ip, ia);
    chk("busy_wr_done", 32'(e >= 0), 32'h1);
    rd(A_STATUS, v); chk("busy_wr_status", 32'(v), 32'h3E);
    rd(A_NUMBER, v); chk("busy_wr_number", 32'(v), 32'd153);
    rd(A_SUM, v);    chk("busy_wr_sum", 32'(v), 32'd153);
    wr(A_STATUS, 16'h0008);
    rd(A_STATUS, v); chk("err_clear", 32'(v), 32'h36);

    // Interrupt assert and deassert timing
    start(16'd370, 16'h0007);
    wait_done(e, fb, ip, ia);
    chk("irq_done_edge", 32'(e), 32'd13);
    chk("irq_before", 32'(ip), 32'h0);
    chk("irq_after", 32'(ia), 32'h1);
    rd(A_SUM, v); chk("irq_sum", 32'(v), 32'd370);
    rd(A_CTRL, v); chk("irq_ctrl", 32'(v), 32'h6);
    wr(A_STATUS, 16'h0002);
    chk("irq_hold", 32'(irq), 32'h1);
    @(posedge clk);
    #1;
    chk("irq_drop", 32'(irq), 32'h0);

    // Done-clear landing on the completion edge
    start(16'd0, 16'h0001);
    repeat (2) @(posedge clk);
    wr(A_STATUS, 16'h0002);
    rd(A_STATUS, v); chk("clr_vs_done", 32'(v), 32'h16);
    wr(A_STATUS, 16'h0002);
    rd(A_STATUS, v); chk("done_clear", 32'(v), 32'h14);

    // Reset in the middle of POWER
    start(16'd65535, 16'h0005);
    repeat (8) @(posedge clk);
    rd(A_STATUS, v); chk("mid_status", 32'(v), 32'h51);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_dout", 32'(dout), 32'h0);
    chk("mid_rst_irq", 32'(irq), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    rd(A_STATUS, v); chk("mid_rst_status", 32'(v), 32'h0);
    rd(A_CTRL, v);   chk("mid_rst_ctrl", 32'(v), 32'h0);
    rd(A_NUMBER, v); chk("mid_rst_number", 32'(v), 32'h0);
    rd(A_SUM, v);    chk("mid_rst_sum", 32'(v), 32'h0);
    repeat (40) @(posedge clk);
    rd(A_STATUS, v); chk("mid_rst_no_done", 32'(v), 32'h0);
    chk("mid_rst_irq_late", 32'(irq), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/armstrong_engine.md
# armstrong_engine

Parametrised, bus-mapped narcissistic (Armstrong) number checker for the SoC peripheral bus. It generalises the fixed 3-digit cube check to any NUM_W-bit operand, and supports two exponent modes: digit-count exponent (true narcissistic) and fixed cube (legacy). Digit extraction and powering are sequential, one step per clock, with a busy/done handshake, sticky error flag and optional interrupt. It sits as a slave on the same chip-select/read/write bus as the other register peripherals.

## Interface
- DATA_W, 16, bus data width (≥ 8)
- NUM_W, 16, operand width (≤ DATA_W); MAX_DIGITS = decimal digits of 2^NUM_W−1 (5 at default), SUM_W = NUM_W+4
- clk  in  1  system clock
- reset_n  in  1  reset; one clock; reset is synchronous and active-low
- iChip_select_n  in  1  chip select, active low
- iWrite_n  in  1  write strobe, active low, qualified by chip select
- iRead_n  in  1  read strobe, active low, qualified by chip select
- iAddr  in  2  register select: 0 CTRL, 1 NUMBER, 2 STATUS, 3 SUM
- data_in  in  DATA_W  write data
- data_out  out  DATA_W  registered read data
- oIrq  out  1  registered interrupt = done & irq_en

## Operation
- CTRL (R/W): bit0 start (write-1 pulse, reads 0), bit1 mode (0 = exponent is digit count D, 1 = exponent fixed at 3), bit2 irq_en.
- NUMBER (R/W): operand in bits [NUM_W−1:0]; upper bits read 0.
- STATUS (R): bit0 busy, bit1 done, bit2 result, bit3 err, bits[7:4] D. Writing 1 to bit1 clears done; writing 1 to bit3 clears err.
- SUM (R): low DATA_W bits of the SUM_W power sum.
- FSM: IDLE → SPLIT → POWER → COMPARE → IDLE.
  - IDLE: start=1 latches NUMBER and mode, clears done/result/sum, sets busy.
  - SPLIT: each cycle stores n%10 into the digit buffer (MAX_DIGITS × 4 bit), n ← n/10, D++. Exits when the updated n==0. Operand 0 gives D=1.
  - POWER: for each digit, p starts at 1 and p ← p·d for E cycles (E = D or 3). sum += p after the last multiply. Exactly D·E cycles.
  - COMPARE: result ← (sum == operand), zero-extended. Clears busy, sets done.
- Writes to NUMBER or CTRL.start while busy are ignored and set err. mode/irq_en writes while busy update CTRL but do not affect the running computation.
- Start while done=1 and idle: clears done and starts a new computation.

## Timing
- Reset: the cycle after reset_n is sampled low, all state returns to IDLE. data_out=0, oIrq=0, CTRL=0, NUMBER=0, STATUS=0, SUM=0, digit buffer cleared. Mid-computation reset aborts with no done.
- Start written at edge 0: busy=1 after edge 0. done=1 and result valid after edge D + D·E + 1.
- Read latency 1: data_out loads on the edge where chip select and read are both low, then holds until the next read.
- Simultaneous read and write to the same register: data_out gets the pre-write value.
- done-clear write on the completion edge: completion wins, done=1.
- oIrq asserts one cycle after done & irq_en becomes true. It deasserts one cycle after done clears or irq_en drops.
- Arithmetic: sum is SUM_W wide and cannot overflow for NUM_W ≤ 16. The comparison uses the full width.

## Structure
- Package armstrong_pkg: FSM state enum, register address constants, STATUS/CTRL bit positions, and the MAX_DIGITS/SUM_W derivation function.
- Sub-module armstrong_digit_step: combinational n → {n/10, n%10}, instantiated once in SPLIT.
- The top level contains the bus decode, FSM, digit buffer and power/accumulate datapath.

## Test plan
- NUMBER=153, mode 0, start → D=3, done after edge 13, result=1, SUM=153, STATUS=0x0036.
- NUMBER=9474, mode 0 → D=4, done after edge 21, result=1, SUM=9474.
- NUMBER=154, mode 0 → result=0, SUM=190. NUMBER=0 → D=1, done after edge 3, result=1, SUM=0.
- NUMBER=1634: mode 1 → result=0, SUM=308, done after edge 17. Mode 0 → result=1, SUM=1634.
- Write NUMBER=5 while busy on 153 → ignored, err=1, result still 1. Write 1 to STATUS bit3 → err=0.
- irq_en=1, run 370 in mode 1 → result=1, oIrq=1 one cycle after done. reset_n low mid-POWER → next cycle busy=0, done=0, data_out=0, oIrq=0.
